// File: rtl/rr_arb8_dec.sv
// Eight-client round-robin arbiter with one-hot grant decode and hold/release handshake.
// Optional hold timeout compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb8_dec #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [2:0] r_gnt_id;
  logic [2:0] w_gnt_id_nxt;
  logic       r_gnt_vld;
  logic       w_gnt_vld_nxt;
  logic       w_win_found;
  logic [2:0] w_win_id;
  logic       w_hold_expired;
  logic       w_norm_release;
  logic       w_release;

  // Returns {found, index}; scanning offsets high-to-low lets the smallest offset win.
  function automatic logic [3:0] rr_pick(input logic [7:0] rq, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (rq[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {w_win_found, w_win_id} = rr_pick(req, r_ptr);

  assign w_norm_release = done | ~req[r_gnt_id];
  assign w_release      = w_norm_release | w_hold_expired;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = r_gnt_vld;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_gnt_id_nxt  = w_win_id;
          w_gnt_vld_nxt = 1'b1;
          w_state_nxt   = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = r_gnt_id + 3'd1;
          w_gnt_id_nxt  = 3'd0;
          w_gnt_vld_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'd0;
      r_gnt_id  <= 3'd0;
      r_gnt_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  assign w_hold_expired = (r_state == S_GRANT) && (r_hold_cnt == HOLD_LAST);

  // Counter sits at zero in IDLE so every new grant starts from a clean count.
  always_comb begin
    w_hold_cnt_nxt = 8'd0;
    w_timeout_nxt  = 1'b0;
    if (r_state == S_GRANT) begin
      if (!w_release) w_hold_cnt_nxt = r_hold_cnt + 8'd1;
      w_timeout_nxt = w_hold_expired & ~w_norm_release;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic w_unused_cfg;

  assign w_unused_cfg   = ^HOLD_LAST;
  assign w_hold_expired = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    gnt = 8'd0;
    if (r_gnt_vld) gnt[r_gnt_id] = 1'b1;
  end

  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Scoreboard bench for rr_arb8_dec: directed scenarios followed by random traffic,
// checked against an ownership-level reference model.
module tb_rr_arb8_dec;

  localparam int TB_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  rr_arb8_dec #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: who owns the resource, where the search starts next,
  // how many cycles the current grant has been visible, and the timeout flag.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
    bit normal;
    bit forced;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_held  = 1;
          break;
        end
      end
    end else begin
      normal = d || !r[m_owner];
      forced = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      forced = (m_held == TB_TIMEOUT);
`endif
      if (normal || forced) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = forced && !normal;
      end else begin
        m_held = m_held + 1;
        m_to   = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    model_edge(r, d, rs);
    e.vld = (m_owner >= 0);
    e.id  = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e.to  = m_to;
    q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || timeout !== e.to) begin
        n_bad++;
        $display("FAIL vec%0d: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                 n_vec, gnt, gnt_id, gnt_vld, timeout, e.gnt, e.id, e.vld, e.to);
      end
    end
  end

  initial begin
    logic [7:0] r;
    // Reset then single request to client 3, released with done
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    // Full-load rotation
    repeat (18) step(8'hFF, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    // Wrap and skip
    step(8'h00, 1'b0, 1'b1);
    step(8'h40, 1'b0, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    step(8'h05, 1'b0, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    step(8'h05, 1'b0, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    // Withdrawal by client 5
    step(8'h00, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    // Mid-grant reset while client 4 owns
    step(8'h10, 1'b0, 1'b0);
    step(8'h10, 1'b0, 1'b0);
    step(8'h10, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    // Long hold with no done: forced release when the timeout is built in
    step(8'h00, 1'b0, 1'b1);
    repeat (12) step(8'h02, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    // done arriving on the same edge the hold limit is reached
    step(8'h00, 1'b0, 1'b1);
    step(8'h02, 1'b0, 1'b0);
    repeat (TB_TIMEOUT - 1) step(8'h02, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'd0;
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    req  = 8'd0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_dec.md
# rr_arb8_dec

Eight-requester round-robin arbiter that shares a single resource among up to eight clients and drives a one-hot grant through a 3-to-8 decode of the registered winner index, gated by a grant-valid enable. It sits between requesting blocks and the shared resource, and sequences ownership with a hold/release handshake. An optional hold timeout forcibly reclaims the resource from a stuck owner.

## Interface
- `TIMEOUT`, default 16: maximum cycles a grant may be held before forced release. Legal range is 2..255. Used only when `RR_ARB_TIMEOUT_EN` is defined.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 8: request vector. Bit i high means client i wants the resource.
- `done` input 1: the current owner releases the resource. Ignored when no grant is active.
- `gnt` output 8: one-hot grant, equal to `1 << gnt_id` when `gnt_vld` is 1, otherwise 8'd0.
- `gnt_id` output 3: index of the current owner. Reads 3'd0 when `gnt_vld` is 0.
- `gnt_vld` output 1: a grant is active.
- `timeout` output 1: one-cycle pulse marking a forced release. Constant 0 when the macro is undefined.

## Operation
- Internal state is a 2-state FSM (IDLE, GRANT), a 3-bit round-robin pointer `ptr`, and, with the macro, a hold counter.
- **IDLE:**
  - If `req` is nonzero, the winner is the first index with `req` set, searching `ptr`, `ptr+1`, … `ptr+7` modulo 8.
  - The winner is registered into `gnt_id`, `gnt_vld` goes to 1, and the FSM moves to GRANT.
  - If `req` is zero, the FSM stays in IDLE.
- **GRANT:** release occurs on any of these conditions:
  - `done`=1, or
  - `req[gnt_id]`=0 (the requester withdrew), or
  - with the macro, the hold counter reaches `TIMEOUT`-1.
- **On release:** `ptr` takes `gnt_id`+1, wrapping 7→0. `gnt_vld` goes to 0, `gnt_id` goes to 0, and the FSM returns to IDLE.
- Requests from other clients during GRANT have no effect on the current owner. There is no preemption.
- `gnt` is a combinational decode of the registered `gnt_id` and `gnt_vld`. It is glitch-free relative to `clk` and never carries more than one bit.
- **Simultaneous events:**
  - `done` together with owner `req` low counts as a single release.
  - `done` in the same cycle the timeout fires is a normal release: `timeout` stays 0, because `done` has priority.
- **Reset:** `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `timeout`=0, `ptr`=0, FSM in IDLE, counter cleared.
  - Reset asserted mid-grant clears everything at that edge, with no release bookkeeping: `ptr` returns to 0, not to owner+1.

## Timing
- **Grant latency:** `req` sampled at edge k while in IDLE → `gnt`/`gnt_vld` valid immediately after edge k.
- **Release latency:** release condition sampled at edge m → `gnt`=0 after edge m.
- **Turnaround:** the earliest next grant is after edge m+1. One mandatory dead cycle separates owners.
- **Minimum grant:** one cycle, if `done` is sampled at the first edge after the grant.
- **Timeout:** the counter clears on entry to GRANT and increments each GRANT cycle. Forced release happens at the edge where the count equals `TIMEOUT`-1, so the grant lasts exactly `TIMEOUT` cycles. `timeout` is high for the single cycle following that edge.
- **Counter width:** 8 bits, with no wrap in the legal range.
- **Throughput under full load:** with `req`=8'hFF and `done` held high, grants cycle 0,1,2,…,7,0 at one grant per two cycles.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- **Defined:** the hold counter, the forced-release path, and the `timeout` pulse are compiled in, and the `TIMEOUT` parameter is honoured.
- **Undefined:** there is no counter logic. `timeout` is tied to 0, a grant lasts until `done` or until the requester withdraws, and `TIMEOUT` is unused.

## Test plan
- **Reset then single request:** `rst` 1 for 2 cycles, then `req`=8'h08 → after the next edge `gnt_vld`=1, `gnt_id`=3, `gnt`=8'h08. With `done` pulsed, `gnt`=8'h00 on the following cycle.
- **Rotation fairness:** `req`=8'hFF, `done` held 1 → grant sequence 0,1,2,3,4,5,6,7,0 with exactly one idle cycle between grants.
- **Wrap and skip:** after a grant to client 6, set `req`=8'h05 → the next grant is client 0; after that release, client 2.
- **Withdrawal:** client 5 granted, then `req[5]` dropped with `done`=0 → `gnt` clears after that edge, and `ptr` is 6 (verified by the next grant choice with `req`=8'hFF giving 6).
- **Mid-grant reset:** client 4 granted, `rst` pulsed for 1 cycle → all outputs 0 the next cycle. Then `req`=8'hFF → client 0 is granted.
- **Timeout (macro defined, `TIMEOUT`=4):** `req`=8'h02 held, `done`=0 → `gnt`=8'h02 for exactly 4 cycles, then `gnt`=0 with `timeout`=1 for 1 cycle, then re-grant to client 1. With the macro undefined, the grant persists indefinitely and `timeout` stays 0.
